// File: rtl/channel_writer.sv
// rtl/channel_writer.sv - pixel-to-SRAM channel writer; optional CHANNEL_WRITER_SATURATE_EN
module channel_writer #(
    parameter int NUM_CH    = 3,
    parameter int CH_W      = 16,
    parameter int OUT_W     = 8,
    parameter int BUS_W     = 16,
    parameter int ADDR_W    = 20,
    parameter int BASE_ADDR = 0,
    parameter int FRAME_PIX = 76800,
    localparam int PC_W     = $clog2(FRAME_PIX + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_CH*CH_W-1:0] in_data,
    input  logic                   frame_start,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [BUS_W-1:0]       wr_data,
    input  logic                   wr_wait,
    output logic                   busy,
    output logic                   frame_done,
    output logic [PC_W-1:0]        pix_count
);

    localparam int CI_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CI_W-1:0]   LAST_CH   = CI_W'(NUM_CH - 1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BASE_ADDR + NUM_CH * FRAME_PIX - 1);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t          state;
    logic [CH_W-1:0] hold [NUM_CH];
    logic [CI_W-1:0] ch_idx;
    logic [CI_W-1:0] nxt_idx;

`ifdef CHANNEL_WRITER_SATURATE_EN
    localparam logic [CH_W-1:0] SAT_MAX = CH_W'((64'd1 << OUT_W) - 64'd1);

    // Signed clamp into [0, 2^OUT_W-1], zero-extended onto the bus
    function automatic logic [BUS_W-1:0] conv(input logic [CH_W-1:0] v);
        logic [BUS_W-1:0] r;
        r = '0;
        if (v[CH_W-1]) begin
            r = '0;
        end else if (v > SAT_MAX) begin
            r[OUT_W-1:0] = '1;
        end else begin
            r[OUT_W-1:0] = v[OUT_W-1:0];
        end
        return r;
    endfunction
`else
    // Plain truncation to OUT_W bits, zero-extended onto the bus
    function automatic logic [BUS_W-1:0] conv(input logic [CH_W-1:0] v);
        logic [BUS_W-1:0] r;
        r = '0;
        r[OUT_W-1:0] = v[OUT_W-1:0];
        return r;
    endfunction
`endif

    // Index of the channel presented after the current one is accepted; kept in range
    always_comb begin
        nxt_idx = '0;
        if (ch_idx != LAST_CH) begin
            nxt_idx = ch_idx + 1'b1;
        end
    end

    // Pixel capture, per-channel write sequencing, frame wrap and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            ch_idx     <= '0;
            wr_addr    <= BASE;
            wr_data    <= '0;
            wr_en      <= 1'b0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            pix_count  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                hold[c] <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    // Frame restart takes effect before a same-cycle pixel capture
                    if (frame_start) begin
                        wr_addr   <= BASE;
                        pix_count <= '0;
                    end
                    if (in_valid) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            hold[c] <= in_data[c*CH_W +: CH_W];
                        end
                        ch_idx   <= '0;
                        wr_data  <= conv(in_data[CH_W-1:0]);
                        wr_en    <= 1'b1;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (!wr_wait) begin
                        wr_addr <= (wr_addr == LAST_ADDR) ? BASE : wr_addr + 1'b1;
                        if (ch_idx == LAST_CH) begin
                            state    <= IDLE;
                            ch_idx   <= '0;
                            wr_en    <= 1'b0;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                            if (wr_addr == LAST_ADDR) begin
                                pix_count  <= '0;
                                frame_done <= 1'b1;
                            end else begin
                                pix_count <= pix_count + 1'b1;
                            end
                        end else begin
                            ch_idx  <= nxt_idx;
                            wr_data <= conv(hold[nxt_idx]);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_channel_writer.sv
// tb/tb_channel_writer.sv - scoreboard bench for channel_writer (BASE_ADDR=16, FRAME_PIX=4)
module tb_channel_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic        frame_start;
    logic        wr_en;
    logic [19:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_wait;
    logic        busy;
    logic        frame_done;
    logic [2:0]  pix_count;

    always #5 clk = ~clk;

    channel_writer #(
        .NUM_CH(3), .CH_W(16), .OUT_W(8), .BUS_W(16), .ADDR_W(20),
        .BASE_ADDR(16), .FRAME_PIX(4)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .frame_start(frame_start), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_wait(wr_wait),
        .busy(busy), .frame_done(frame_done), .pix_count(pix_count)
    );

    typedef struct packed {
        logic [19:0] a;
        logic [15:0] d;
        logic        last;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    logic        mon_en = 1'b0;
    logic        exp_done = 1'b0;
    logic        stalled_prev = 1'b0;
    logic [19:0] st_a;
    logic [15:0] st_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: pops an expected word on every accepted write
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            chk("frame_done", {31'd0, frame_done}, {31'd0, exp_done});
            exp_done = 1'b0;
            if (stalled_prev && wr_en) begin
                chk("stall_addr", {12'd0, wr_addr}, {12'd0, st_a});
                chk("stall_data", {16'd0, wr_data}, {16'd0, st_d});
            end
            if (rst && wr_en && !wr_wait) begin
                if (q.size() == 0) begin
                    chk("unexpected_write", {12'd0, wr_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("wr_addr", {12'd0, wr_addr}, {12'd0, e.a});
                    chk("wr_data", {16'd0, wr_data}, {16'd0, e.d});
                    exp_done = e.last;
                end
            end
            stalled_prev = rst && wr_en && wr_wait;
            st_a = wr_addr;
            st_d = wr_data;
            if (frame_done) done_cnt++;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2,
                        input logic fs, input logic [19:0] a0,
                        input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                        input int npush);
        logic [15:0] dv [3];
        exp_t e;
        dv[0] = d0; dv[1] = d1; dv[2] = d2;
        wait_idle();
        for (int i = 0; i < npush; i++) begin
            e.a    = a0 + 20'(i);
            e.d    = dv[i];
            e.last = (a0 + 20'(i) == 20'd27);
            q.push_back(e);
        end
        in_data     = {c2, c1, c0};
        in_valid    = 1'b1;
        frame_start = fs;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        frame_start = 1'b0;
        in_data     = 48'hDEAD_BEEF_CAFE;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; frame_start = 1'b0; wr_wait = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_addr", {12'd0, wr_addr}, 32'd16);
        chk("rst_wr_data", {16'd0, wr_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pix_count", {29'd0, pix_count}, 32'd0);
        rst = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Basic pixel with exact handshake timing
        send(16'h0012, 16'h0034, 16'h0056, 1'b0, 20'd16, 16'h12, 16'h34, 16'h56, 3);
        chk("p0_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("p0_busy", {31'd0, busy}, 32'd1);
        chk("p0_wr_en", {31'd0, wr_en}, 32'd1);
        repeat (2) begin @(posedge clk); #1; end
        chk("p0_in_ready_k3", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("p0_in_ready_k4", {31'd0, in_ready}, 32'd1);
        chk("p0_busy_end", {31'd0, busy}, 32'd0);
        chk("p0_pix_count", {29'd0, pix_count}, 32'd1);

        // Two stall cycles during channel 1
        send(16'h0012, 16'h0034, 16'h0056, 1'b0, 20'd19, 16'h12, 16'h34, 16'h56, 3);
        @(posedge clk); #1;
        wr_wait = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        wr_wait = 1'b0;
        wait_idle();
        chk("p1_pix_count", {29'd0, pix_count}, 32'd2);

        // Conversion of out-of-range channel values
`ifdef CHANNEL_WRITER_SATURATE_EN
        send(16'h0180, 16'hFFF0, 16'h007F, 1'b0, 20'd22, 16'hFF, 16'h00, 16'h7F, 3);
`else
        send(16'h0180, 16'hFFF0, 16'h007F, 1'b0, 20'd22, 16'h80, 16'hF0, 16'h7F, 3);
`endif
        wait_idle();
        chk("p2_pix_count", {29'd0, pix_count}, 32'd3);

        // Last pixel of the frame: wrap and frame_done
        send(16'h00AB, 16'h00CD, 16'h00EF, 1'b0, 20'd25, 16'hAB, 16'hCD, 16'hEF, 3);
        wait_idle();
        chk("p3_frame_done", {31'd0, frame_done}, 32'd1);
        chk("p3_pix_count", {29'd0, pix_count}, 32'd0);
        chk("p3_wr_addr", {12'd0, wr_addr}, 32'd16);

        send(16'h0001, 16'h0002, 16'h0003, 1'b0, 20'd16, 16'h01, 16'h02, 16'h03, 3);
        wait_idle();
        chk("p4_pix_count", {29'd0, pix_count}, 32'd1);

        // frame_start during WRITE is ignored
        send(16'h0004, 16'h0005, 16'h0006, 1'b0, 20'd19, 16'h04, 16'h05, 16'h06, 3);
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        wait_idle();
        chk("p5_pix_count", {29'd0, pix_count}, 32'd2);

        // frame_start together with in_valid restarts at base
        send(16'h0007, 16'h0008, 16'h0009, 1'b1, 20'd16, 16'h07, 16'h08, 16'h09, 3);
        wait_idle();
        chk("p6_pix_count", {29'd0, pix_count}, 32'd1);

        // Reset during channel 1 abandons the pixel
        send(16'h0011, 16'h0022, 16'h0033, 1'b0, 20'd19, 16'h11, 16'h22, 16'h33, 1);
        @(posedge clk); #1;
        wr_wait = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rstmid_wr_addr", {12'd0, wr_addr}, 32'd16);
        chk("rstmid_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rstmid_pix_count", {29'd0, pix_count}, 32'd0);
        rst = 1'b1;
        wr_wait = 1'b0;

        send(16'h0044, 16'h0055, 16'h0066, 1'b0, 20'd16, 16'h44, 16'h55, 16'h66, 3);
        wait_idle();
        chk("p8_pix_count", {29'd0, pix_count}, 32'd1);

        repeat (3) begin @(posedge clk); #1; end
        chk("queue_empty", q.size(), 32'd0);
        chk("frame_done_count", done_cnt, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/channel_writer.md
# channel_writer

Parametrised pixel writer between the NN core output ports and the SRAM controller's write interface. It accepts one pixel of NUM_CH channel results per handshake and writes each channel as its own word to consecutive SRAM addresses. It supports stall-aware writes (waitrequest), a programmable frame base and length with wrap-around, and a frame-done strobe. It generalises the fixed three-channel, free-running colorizer path to any channel count, width and frame size.

## Interface
- NUM_CH, 3: channels per pixel (1..8)
- CH_W, 16: width of each NN core output channel
- OUT_W, 8: significant bits written per channel (OUT_W ≤ CH_W, OUT_W ≤ BUS_W)
- BUS_W, 16: SRAM write-data width
- ADDR_W, 20: SRAM word-address width
- BASE_ADDR, 0: first word address of a frame
- FRAME_PIX, 76800: pixels per frame (≥1; NUM_CH·FRAME_PIX ≤ 2^ADDR_W)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous and active-low, sampled on the rising edge of clk
- in_valid  in  1  pixel data valid
- in_ready  out  1  block can accept a pixel
- in_data  in  NUM_CH·CH_W  channel c at bits [c·CH_W +: CH_W]; channel 0 written first
- frame_start  in  1  restart the address at BASE_ADDR (honoured only in IDLE)
- wr_en  out  1  write request to SRAM controller
- wr_addr  out  ADDR_W  write word address
- wr_data  out  BUS_W  write data, zero-extended from OUT_W
- wr_wait  in  1  controller stall; current write is held while high
- busy  out  1  high in WRITE state
- frame_done  out  1  one-cycle pulse after the last word of a frame is accepted
- pix_count  out  ceil(log2(FRAME_PIX+1))  pixels completed in the current frame

## Operation
- States: IDLE, WRITE.
- IDLE: in_ready=1, wr_en=0. On in_valid: latch all channels into a holding register, set ch_idx=0, go to WRITE.
- frame_start in IDLE: word address ← BASE_ADDR, pix_count ← 0. If asserted together with in_valid, the reset applies first and the pixel is written starting at BASE_ADDR. frame_start in WRITE is ignored.
- WRITE: in_ready=0, wr_en=1, wr_data=conv(hold[ch_idx]), wr_addr=current word address.
  - Write accepted when wr_en && !wr_wait: address +1 and ch_idx +1.
  - After channel NUM_CH−1 is accepted: pix_count +1 and return to IDLE.
  - While wr_wait=1, wr_addr, wr_data and ch_idx hold.
- Frame wrap: when the accepted word is the last word of the frame (address BASE_ADDR+NUM_CH·FRAME_PIX−1), the address becomes BASE_ADDR, pix_count becomes 0 and frame_done pulses on the next cycle.
- conv(): truncate to the low OUT_W bits and zero-extend to BUS_W (see Configuration).
- in_data changes after capture have no effect on an in-progress pixel.
- Reset (rst=0 at an edge) from any state, including mid-pixel: state=IDLE, address=BASE_ADDR, ch_idx=0, pix_count=0. The partially written pixel is abandoned and no further writes are issued.

## Timing
- Reset values: in_ready=1, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, busy=0, frame_done=0, pix_count=0.
- Capture at edge k gives wr_en=1 from cycle k+1. With wr_wait=0, channels occupy cycles k+1..k+NUM_CH and in_ready returns at k+NUM_CH+1.
- Throughput: one pixel per NUM_CH+1 cycles, plus stall cycles.
- frame_done is high for exactly the cycle after the final accepted write of the frame, which is the same cycle in_ready returns.
- All outputs are registered; there is no combinational path from an input to an output.

## Configuration
- CHANNEL_WRITER_SATURATE_EN
  - Defined: each channel is treated as a signed CH_W value. Negative values produce 0, values above 2^OUT_W−1 produce 2^OUT_W−1, and other values pass through.
  - Undefined: plain truncation to the low OUT_W bits, with no sign interpretation.

## Test plan
- Reset, then a pixel with channels {0x0012, 0x0034, 0x0056}, wr_wait=0 -> writes at addresses 0,1,2 with data 0x12,0x34,0x56 on three consecutive cycles; in_ready returns 4 cycles after capture; pix_count=1.
- Same pixel with wr_wait high for 2 cycles during channel 1 -> address 1 and data 0x34 held for 3 cycles, then addresses continue 2,3… with no skipped or duplicated write.
- FRAME_PIX=2, three pixels -> addresses 0..5, then 0..2. frame_done pulses once, the cycle after the write to address 5. pix_count sequence is 1,0,1.
- rst=0 asserted during channel 1 of pixel 0 -> wr_en=0 next cycle. A following pixel writes at BASE_ADDR.
- Channels {0x0180, 0xFFF0, 0x007F}: with CHANNEL_WRITER_SATURATE_EN the writes are 0xFF,0x00,0x7F; without it the writes are 0x80,0xF0,0x7F.
- frame_start with in_valid in IDLE after 5 pixels -> pixel written from BASE_ADDR and pix_count restarts at 1. frame_start pulsed during WRITE -> no effect.
